// File: rtl/vga_pkg.sv
// vga_pkg: shared widths, swap FSM encoding and
// default window geometry for the VGA pixel fetch block.
package vga_pkg;

  localparam int RGB4_W   = 4;
  localparam int RGB444_W = 12;
  localparam int RGB8_W   = 8;

  localparam int WIN_W_DEF  = 160;
  localparam int WIN_H_DEF  = 120;
  localparam int ADDR_W_DEF = 15;

  typedef logic [RGB444_W-1:0] rgb444_t;
  typedef logic [RGB8_W-1:0]   rgb8_t;

  typedef enum logic [1:0] {
    SW_IDLE    = 2'd0,
    SW_PENDING = 2'd1,
    SW_ACK     = 2'd2
  } swap_e;

  // Delay-line lane layout: {video, nblank, vsync, hsync}.
  localparam int DL_WIDTH = 4;
  localparam int DL_DEPTH = 3;
  localparam int DL_HS    = 0;
  localparam int DL_VS    = 1;
  localparam int DL_NB    = 2;
  localparam int DL_VID   = 3;
  localparam logic [DL_WIDTH-1:0] DL_RST = 4'b0011;

  function automatic rgb8_t x8(input logic [RGB4_W-1:0] n);
    return {n, n};
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth shift register with every
// stage exposed as a tap; resets to a chosen idle word.
module vga_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [WIDTH-1:0]            d_i,
  output logic [DEPTH-1:0][WIDTH-1:0] taps_o
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;
  logic [DEPTH-1:0][WIDTH-1:0] sr_d;

  assign sr_d = {sr_q[DEPTH-2:0], d_i};

  // Shift one stage per clock; stage 0 is the newest.
  always_ff @(posedge clk_i) begin
    if (rst_i) sr_q <= {DEPTH{RST_VAL}};
    else       sr_q <= sr_d;
  end

  assign taps_o = sr_q;

endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: 3-stage frame-buffer fetch and colour
// pipeline with a vsync-aligned double-buffer bank swap.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int unsigned WIN_W      = WIN_W_DEF,
  parameter int unsigned WIN_H      = WIN_H_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter rgb444_t     BORDER_RGB = 12'h000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic              i_video,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_nblank,
  output logic [ADDR_W:0]   o_rd_addr,
  output logic              o_rd_en,
  input  rgb444_t           i_rd_data,
  input  logic              i_swap_req,
  output logic              o_swap_ack,
  output logic [RGB8_W-1:0] o_r,
  output logic [RGB8_W-1:0] o_g,
  output logic [RGB8_W-1:0] o_b,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_nblank,
  output logic              o_nsync
);

  localparam int unsigned NPIX = WIN_W * WIN_H;
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NPIX - 1);

  logic              vs_q;
  logic              boundary;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              bank_q, bank_d;
  swap_e             st_q, st_d;
  logic              ack_q, ack_d;
  logic              en_q;
  logic [ADDR_W:0]   addr_q, addr_d;
  rgb444_t           rgb_sel;
  rgb8_t             r_q, g_q, b_q;
  logic              unused_sig;

  logic [DL_DEPTH-1:0][DL_WIDTH-1:0] taps;

  assign boundary = vs_q & ~i_vsync;

  // Pixel counter: restarts at the frame boundary, wraps at window end.
  always_comb begin
    cnt_d = cnt_q;
    if (boundary)
      cnt_d = '0;
    else if (i_video)
      cnt_d = (cnt_q == PIX_LAST) ? '0 : cnt_q + ADDR_W'(1);
  end

  assign addr_d = i_video ? {bank_q, cnt_q} : addr_q;

  // Swap FSM: the bank only ever flips on the frame boundary.
  always_comb begin
    st_d   = st_q;
    bank_d = bank_q;
    ack_d  = 1'b0;
    unique case (st_q)
      SW_IDLE: begin
        if (i_swap_req && boundary) begin
          bank_d = ~bank_q;
          ack_d  = 1'b1;
          st_d   = SW_ACK;
        end else if (i_swap_req) begin
          st_d = SW_PENDING;
        end
      end
      SW_PENDING: begin
        if (boundary) begin
          bank_d = ~bank_q;
          ack_d  = 1'b1;
          st_d   = SW_ACK;
        end
      end
      SW_ACK: begin
        if (!i_swap_req) st_d = SW_IDLE;
      end
      default: st_d = SW_IDLE;
    endcase
  end

  // S1: frame tracking, swap state and read request registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_q   <= 1'b1;
      cnt_q  <= '0;
      bank_q <= 1'b0;
      st_q   <= SW_IDLE;
      ack_q  <= 1'b0;
      en_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      vs_q   <= i_vsync;
      cnt_q  <= cnt_d;
      bank_q <= bank_d;
      st_q   <= st_d;
      ack_q  <= ack_d;
      en_q   <= i_video;
      addr_q <= addr_d;
    end
  end

  vga_delay_line #(
    .WIDTH   (DL_WIDTH),
    .DEPTH   (DL_DEPTH),
    .RST_VAL (DL_RST)
  ) u_dly (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .d_i    ({i_video, i_nblank, i_vsync, i_hsync}),
    .taps_o (taps)
  );

  // Colour source picked with the stage-2 video/blank flags.
  always_comb begin
    rgb_sel = '0;
    if (taps[1][DL_NB])
      rgb_sel = taps[1][DL_VID] ? i_rd_data : BORDER_RGB;
  end

  // S3: expand RGB444 to RGB888 into the DAC registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= x8(rgb_sel[11:8]);
      g_q <= x8(rgb_sel[7:4]);
      b_q <= x8(rgb_sel[3:0]);
    end
  end

  assign o_rd_addr  = addr_q;
  assign o_rd_en    = en_q;
  assign o_swap_ack = ack_q;
  assign o_r        = r_q;
  assign o_g        = g_q;
  assign o_b        = b_q;
  assign o_hsync    = taps[2][DL_HS];
  assign o_vsync    = taps[2][DL_VS];
  assign o_nblank   = taps[2][DL_NB];
  assign o_nsync    = 1'b1;

  assign unused_sig = ^{i_x, i_y, taps[0],
                        taps[1][DL_VS:DL_HS],
                        taps[2][DL_VID]};

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: randomized frames checked every cycle
// against a frame-level model, plus literal scenario checks.
module tb_vga_pixel_fetch;

  localparam int NPIX = 160 * 120;
  localparam logic [11:0] BRD = 12'h5A3;
  localparam int H_TOT = 172;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [9:0]  i_x = '0;
  logic [9:0]  i_y = '0;
  logic        i_video = 1'b0;
  logic        i_hsync = 1'b1;
  logic        i_vsync = 1'b1;
  logic        i_nblank = 1'b0;
  logic [15:0] o_rd_addr;
  logic        o_rd_en;
  logic [11:0] i_rd_data = '0;
  logic        i_swap_req = 1'b0;
  logic        o_swap_ack;
  logic [7:0]  o_r, o_g, o_b;
  logic        o_hsync, o_vsync, o_nblank, o_nsync;

  int vectors = 0;
  int miscompares = 0;
  int ack_cnt = 0;
  bit checking = 1'b0;
  logic [15:0] first_addr;
  logic        fall_ack;

  vga_pixel_fetch #(.BORDER_RGB(BRD)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_x        (i_x),
    .i_y        (i_y),
    .i_video    (i_video),
    .i_hsync    (i_hsync),
    .i_vsync    (i_vsync),
    .i_nblank   (i_nblank),
    .o_rd_addr  (o_rd_addr),
    .o_rd_en    (o_rd_en),
    .i_rd_data  (i_rd_data),
    .i_swap_req (i_swap_req),
    .o_swap_ack (o_swap_ack),
    .o_r        (o_r),
    .o_g        (o_g),
    .o_b        (o_b),
    .o_hsync    (o_hsync),
    .o_vsync    (o_vsync),
    .o_nblank   (o_nblank),
    .o_nsync    (o_nsync)
  );

  always #5 i_clk = ~i_clk;

  // Frame-buffer model: one-cycle read, data = addr[11:0].
  always @(posedge i_clk)
    i_rd_data <= o_rd_en ? o_rd_addr[11:0] : 12'($urandom);

  function automatic logic [23:0] ex(input logic [11:0] c);
    return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
  endfunction

  // Reference model: pixel index, bank and request bookkeeping.
  int          pix;
  bit          bank, want, served, vprev, fall, take;
  logic        m_en, m_ack;
  logic [15:0] m_addr;
  logic [26:0] pipe [3];
  logic [26:0] nw;

  always @(posedge i_clk) begin
    if (i_rst) begin
      pix = 0; bank = 0; want = 0; served = 0; vprev = 1;
      m_en = 0; m_ack = 0; m_addr = '0;
      for (int k = 0; k < 3; k++) pipe[k] = {24'h0, 3'b110};
    end else begin
      fall = vprev && !i_vsync;
      take = fall && !served && (want || i_swap_req);
      m_en = i_video;
      if (i_video) m_addr = {bank, 15'(pix)};
      if (!i_nblank)    nw[26:3] = 24'h0;
      else if (i_video) nw[26:3] = ex(12'(pix));
      else              nw[26:3] = ex(BRD);
      nw[2:0] = {i_hsync, i_vsync, i_nblank};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nw;
      if (fall)         pix = 0;
      else if (i_video) pix = (pix + 1) % NPIX;
      if (take) begin
        bank = !bank; served = 1; want = 0;
      end else if (served) begin
        if (!i_swap_req) served = 0;
      end else if (i_swap_req) begin
        want = 1;
      end
      m_ack = take;
      vprev = i_vsync;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge i_clk) begin
    if (checking) begin
      vectors++;
      if ({o_rd_en, o_rd_addr, o_swap_ack} !== {m_en, m_addr, m_ack} ||
          {o_r, o_g, o_b, o_hsync, o_vsync, o_nblank} !== pipe[2] ||
          o_nsync !== 1'b1) begin
        miscompares++;
        $display("FAIL cycle @%0t en/addr/ack got %b/%h/%b want %b/%h/%b rgbsync got %h want %h nsync %b",
                 $time, o_rd_en, o_rd_addr, o_swap_ack, m_en, m_addr, m_ack,
                 {o_r, o_g, o_b, o_hsync, o_vsync, o_nblank}, pipe[2], o_nsync);
      end
      if (o_swap_ack === 1'b1) ack_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input bit vid,
                       input bit nb, input bit hs, input bit vs);
    i_x = 10'(x);
    i_y = 10'(y);
    i_video = vid;
    i_nblank = nb;
    i_hsync = hs;
    i_vsync = vs;
    @(posedge i_clk);
    #1;
  endtask

  // One frame: nv window lines, a border line, vsync at nv+2..nv+3.
  task automatic frame(input int nv, input bit pin, input int req_line,
                       input bit req_fall, input int rst_line,
                       input bit rnd);
    for (int y = 0; y < nv + 5; y++) begin
      for (int x = 0; x < H_TOT; x++) begin
        if (y == req_line && x == 0) i_swap_req = 1'b1;
        if (req_fall && y == nv + 2 && x == 0) i_swap_req = 1'b1;
        if (rnd && x == 0 && $urandom_range(0, 3) == 0)
          i_swap_req = ~i_swap_req;
        i_rst = (y == rst_line && x == 0) ||
                (rnd && $urandom_range(0, 4999) == 0);
        if (i_rst) i_swap_req = 1'b0;
        drive(x, y, (y < nv && x < 160), (y <= nv && x < 164),
              !(x >= 166 && x < 170), !(y == nv + 2 || y == nv + 3));
        if (y == 0 && x == 0) first_addr = o_rd_addr;
        if (y == nv + 2 && x == 0) fall_ack = o_swap_ack;
        if (i_rst) begin
          chk("rst_addr", 32'(o_rd_addr), 0);
          chk("rst_en", 32'(o_rd_en), 0);
          chk("rst_vsync", 32'(o_vsync), 1);
          chk("rst_ack", 32'(o_swap_ack), 0);
        end
        if (pin && y == 0 && x == 2)
          chk("pix00_rgb", 32'({o_r, o_g, o_b}), 0);
        if (pin && y == 0 && x == 7)
          chk("pix50_rgb", 32'({o_r, o_g, o_b}), 32'h000055);
        if (pin && y == 119 && x == 159) begin
          chk("last_addr", 32'(o_rd_addr), 19199);
          chk("last_en", 32'(o_rd_en), 1);
        end
        if (pin && y == 120 && x == 0)
          chk("wrap_addr", 32'(o_rd_addr), 0);
      end
    end
    i_rst = 1'b0;
  endtask

  initial begin
    int s0;
    i_rst = 1'b1;
    repeat (3) drive(0, 0, 0, 0, 1, 1);
    checking = 1'b1;
    i_rst = 1'b0;
    chk("reset_en", 32'(o_rd_en), 0);
    chk("reset_addr", 32'(o_rd_addr), 0);
    chk("reset_sync", 32'({o_hsync, o_vsync, o_nblank}), 3'b110);
    chk("reset_rgb", 32'({o_r, o_g, o_b}), 0);
    chk("reset_ack", 32'(o_swap_ack), 0);

    frame(121, 1, -1, 0, -1, 0);

    drive(200, 50, 0, 1, 1, 1);
    drive(200, 50, 0, 1, 1, 1);
    chk("border_early", 32'({o_r, o_g, o_b}), 0);
    drive(200, 50, 0, 1, 1, 1);
    chk("border_rgb", 32'({o_r, o_g, o_b}), 32'h55AA33);
    chk("border_en", 32'(o_rd_en), 0);
    chk("border_addr_held", 32'(o_rd_addr), 159);

    s0 = ack_cnt;
    frame(3, 0, 1, 0, -1, 0);
    chk("swap_ack_at_fall", 32'(fall_ack), 1);
    chk("swap_one_ack", 32'(ack_cnt - s0), 1);
    frame(3, 0, -1, 0, -1, 0);
    chk("bank1_addr", 32'(first_addr), 32'h8000);
    frame(3, 0, -1, 0, -1, 0);
    chk("held_bank1", 32'(first_addr), 32'h8000);
    chk("held_one_ack", 32'(ack_cnt - s0), 1);
    i_swap_req = 1'b0;
    frame(3, 0, -1, 0, -1, 0);
    frame(3, 0, 1, 0, -1, 0);
    chk("reraise_ack", 32'(ack_cnt - s0), 2);
    frame(3, 0, -1, 0, -1, 0);
    chk("bank0_addr", 32'(first_addr), 0);

    i_swap_req = 1'b0;
    frame(3, 0, -1, 0, -1, 0);
    s0 = ack_cnt;
    frame(3, 0, -1, 1, -1, 0);
    chk("samecyc_ack", 32'(fall_ack), 1);
    chk("samecyc_count", 32'(ack_cnt - s0), 1);
    frame(3, 0, -1, 0, -1, 0);
    chk("samecyc_bank1", 32'(first_addr), 32'h8000);

    i_swap_req = 1'b0;
    frame(3, 0, -1, 0, -1, 0);
    s0 = ack_cnt;
    frame(64, 0, 10, 0, 60, 0);
    chk("rst_no_ack_fall", 32'(fall_ack), 0);
    chk("rst_no_ack", 32'(ack_cnt - s0), 0);
    frame(3, 0, -1, 0, -1, 0);
    chk("rst_bank0", 32'(first_addr), 0);

    repeat (8) frame($urandom_range(1, 4), 0, -1, 0, -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
